array_seq_ctrl: RTL and testbench

ARRAY_SEQ_CTRL -- requirements
Module: array_seq_ctrl

---
 rtl/array_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_array_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_seq_ctrl.sv
// Array sequencer: accepts one command, then steps IDLE -> SETUP -> ACTIVE -> DONE.
// Define ARRAY_BCAST_EN to turn op 11 into an all-bank write; otherwise op 11 is a NOP.
module array_seq_ctrl #(
    parameter int unsigned NUM_BANKS = 16,
    parameter int unsigned MAC_CYC   = 4,
    parameter int unsigned WR_CYC    = 2,
    localparam int unsigned SEL_W    = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           op_code,
    input  logic [SEL_W-1:0]     bank_sel,
    input  logic [7:0]           word,
    input  logic                 abort,
    output logic [7:0]           word_q,
    output logic                 mac_en,
    output logic                 read_bar,
    output logic                 w_en,
    output logic [NUM_BANKS-1:0] bank_en,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {StIdle, StSetup, StActive, StDone} state_e;

    localparam logic [1:0]   OpMac   = 2'b00;
    localparam logic [1:0]   OpRead  = 2'b01;
    localparam logic [1:0]   OpBcast = 2'b11;
    localparam logic [7:0]   MacLd   = 8'(MAC_CYC - 1);
    localparam logic [7:0]   WrLd    = 8'(WR_CYC - 1);
    localparam logic [SEL_W:0] NbLim = (SEL_W + 1)'(NUM_BANKS);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       word_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       len_ld;
    logic             sel_bad;
    logic [NUM_BANKS-1:0] sel_mask;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 2'b00;
            sel_q   <= '0;
            word_q  <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        len_ld = WrLd;
        if (op_code == OpMac) begin
            len_ld = MacLd;
        end else if (op_code == OpRead) begin
            len_ld = 8'h00;
        end
    end

    assign sel_bad = ({1'b0, bank_sel} >= NbLim);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d   = op_code;
                    sel_d  = bank_sel;
                    word_d = word;
                    cnt_d  = len_ld;
                    err_d  = 1'b0;
                    if (op_code == OpBcast) begin
`ifdef ARRAY_BCAST_EN
                        state_d = StSetup;
`else
                        state_d = StDone;
`endif
                    end else if (sel_bad) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (abort) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    state_d = StActive;
                end
            end
            StActive: begin
                // Abort takes priority even on the final active cycle
                if (abort) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else if (cnt_q == 8'h00) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 8'h01;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        sel_mask = {{(NUM_BANKS - 1){1'b0}}, 1'b1} << sel_q;
`ifdef ARRAY_BCAST_EN
        if (op_q == OpBcast) begin
            sel_mask = {NUM_BANKS{1'b1}};
        end
`endif
    end

    // Output decode
    always_comb begin
        cmd_ready = 1'b0;
        bank_en   = '0;
        mac_en    = 1'b0;
        read_bar  = 1'b1;
        w_en      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = rst_n;
            end
            StSetup: begin
                bank_en = sel_mask;
            end
            StActive: begin
                bank_en = sel_mask;
                unique case (op_q)
                    OpMac:   mac_en   = 1'b1;
                    OpRead:  read_bar = 1'b0;
                    default: w_en     = 1'b1;
                endcase
            end
            StDone: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_array_seq_ctrl.sv
// Bench for array_seq_ctrl: directed table, hold/reset sequences and random commands
// checked against a per-cycle behavioural model; runs a 16-bank and a 12-bank instance.
module tb_array_seq_ctrl;

    localparam int MAC_CYC = 4;
    localparam int WR_CYC  = 2;
`ifdef ARRAY_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef struct packed {
        logic        rdy;
        logic [15:0] ben;
        logic        mac;
        logic        rdb;
        logic        wen;
        logic        dn;
        logic        er;
        logic [7:0]  wq;
    } outs_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        int          sel;
        logic [7:0]  w;
        int          ab;
        bit          b12;
        logic [15:0] exp_ben;
        int          exp_dc;
        bit          exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cmd_valid, abort, use12;
    logic [1:0] op_code;
    logic [3:0] bank_sel;
    logic [7:0] word;

    logic        rdy16, mac16, rdb16, wen16, dn16, er16;
    logic [7:0]  wq16;
    logic [15:0] ben16;
    logic        rdy12, mac12, rdb12, wen12, dn12, er12;
    logic [7:0]  wq12;
    logic [11:0] ben12;
    outs_t       act;

    int n_tests = 0;
    int n_fail  = 0;

    array_seq_ctrl #(.NUM_BANKS(16), .MAC_CYC(MAC_CYC), .WR_CYC(WR_CYC)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & ~use12), .cmd_ready(rdy16),
        .op_code(op_code), .bank_sel(bank_sel), .word(word), .abort(abort & ~use12),
        .word_q(wq16), .mac_en(mac16), .read_bar(rdb16), .w_en(wen16), .bank_en(ben16),
        .done(dn16), .err(er16)
    );

    array_seq_ctrl #(.NUM_BANKS(12), .MAC_CYC(MAC_CYC), .WR_CYC(WR_CYC)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid & use12), .cmd_ready(rdy12),
        .op_code(op_code), .bank_sel(bank_sel), .word(word), .abort(abort & use12),
        .word_q(wq12), .mac_en(mac12), .read_bar(rdb12), .w_en(wen12), .bank_en(ben12),
        .done(dn12), .err(er12)
    );

    always_comb begin
        if (use12) act = {rdy12, 4'h0, ben12, mac12, rdb12, wen12, dn12, er12, wq12};
        else       act = {rdy16, ben16, mac16, rdb16, wen16, dn16, er16, wq16};
    end

    function automatic int act_len(logic [1:0] op);
        if (op == 2'b00) return MAC_CYC;
        if (op == 2'b01) return 1;
        return WR_CYC;
    endfunction

    function automatic bit is_skip(logic [1:0] op, int sel, int nb);
        if (op == 2'b11) return !BCAST;
        return sel >= nb;
    endfunction

    function automatic int done_cyc(logic [1:0] op, int sel, int ab, int nb);
        if (is_skip(op, sel, nb)) return 1;
        if (ab != 0) return ab + 1;
        return act_len(op) + 2;
    endfunction

    // Expected outputs k cycles after the accept edge
    function automatic outs_t model(logic [1:0] op, int sel, logic [7:0] w, int ab, int nb,
                                    int k);
        outs_t o;
        logic [15:0] mask;
        int dc;
        dc = done_cyc(op, sel, ab, nb);
        o = '0;
        o.rdb = 1'b1;
        o.wq = w;
        if (op == 2'b11 && BCAST) mask = 16'((32'd1 << nb) - 32'd1);
        else                      mask = 16'(32'd1 << sel);
        if (!is_skip(op, sel, nb) && k < dc) begin
            o.ben = mask;
            if (k >= 2) begin
                if (op == 2'b00)      o.mac = 1'b1;
                else if (op == 2'b01) o.rdb = 1'b0;
                else                  o.wen = 1'b1;
            end
        end else if (k == dc) begin
            o.dn = 1'b1;
            o.er = is_skip(op, sel, nb) ? (op != 2'b11) : (ab != 0);
        end
        return o;
    endfunction

    task automatic check(string name, outs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(string name, logic got, logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Runs one command from the current negedge; returns at the negedge of the next IDLE cycle
    task automatic run_cmd(string name, logic [1:0] op, int sel, logic [7:0] w, int ab,
                           bit b12, bit hold, bit tbl, logic [15:0] t_ben, int t_dc,
                           bit t_err);
        int t = 0;
        int nb, dc;
        nb = b12 ? 12 : 16;
        use12 = b12;
        #1;
        while (!act.rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!act.rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got cmd_ready=0 expected 1", name);
            return;
        end
        cmd_valid = 1'b1;
        op_code   = op;
        bank_sel  = 4'(sel);
        word      = w;
        @(negedge clk);
        dc = done_cyc(op, sel, ab, nb);
        if (tbl) check_bit({name, "_dc"}, 1'b1, 1'(dc == t_dc));
        for (int k = 1; k <= dc; k++) begin
            check(name, model(op, sel, w, ab, nb, k));
            if (tbl) begin
                n_tests++;
                if (act.ben !== (k < t_dc ? t_ben : 16'h0) || act.dn !== (k == t_dc) ||
                    act.er !== (k == t_dc && t_err)) begin
                    n_fail++;
                    $display("FAIL %s_tbl k=%0d: got ben=%h done=%b err=%b", name, k,
                             act.ben, act.dn, act.er);
                end
            end
            if (hold) begin
                cmd_valid = 1'b1;
                op_code   = 2'b10;
                bank_sel  = 4'd0;
                word      = 8'h3C;
            end else begin
                cmd_valid = 1'($urandom);
                op_code   = 2'($urandom);
                bank_sel  = 4'($urandom);
                word      = 8'($urandom);
            end
            abort = (k == ab) || (k == dc && 1'($urandom));
            @(negedge clk);
        end
        abort     = 1'b0;
        cmd_valid = hold;
    endtask

    task automatic check_reset_outs(string name);
        check(name, outs_t'({1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; use12 = 1'b0;
        op_code = 2'b00; bank_sel = 4'd0; word = 8'h00;

        vecs.push_back('{"mac_b5", 2'b00, 5, 8'hA5, 0, 1'b0, 16'h0020, 6, 1'b0});
        vecs.push_back('{"rd_b15", 2'b01, 15, 8'h12, 0, 1'b0, 16'h8000, 3, 1'b0});
        vecs.push_back('{"wr_b0", 2'b10, 0, 8'h34, 0, 1'b0, 16'h0001, 4, 1'b0});
        vecs.push_back('{"mac_abort_act2", 2'b00, 3, 8'h56, 3, 1'b0, 16'h0008, 4, 1'b1});
        vecs.push_back('{"nb12_sel13", 2'b00, 13, 8'h78, 0, 1'b1, 16'h0000, 1, 1'b1});
        vecs.push_back('{"op3_b16", 2'b11, 2, 8'h9A, 0, 1'b0,
                         BCAST ? 16'hFFFF : 16'h0000, BCAST ? 4 : 1, 1'b0});
        vecs.push_back('{"op3_nb12_sel14", 2'b11, 14, 8'hBC, 0, 1'b1,
                         BCAST ? 16'h0FFF : 16'h0000, BCAST ? 4 : 1, 1'b0});
        vecs.push_back('{"wr_abort_setup", 2'b10, 9, 8'hDE, 1, 1'b0, 16'h0200, 2, 1'b1});
        vecs.push_back('{"mac_abort_last", 2'b00, 6, 8'hF0, 5, 1'b0, 16'h0040, 6, 1'b1});
        vecs.push_back('{"rd_nb12_b11", 2'b01, 11, 8'h0F, 0, 1'b1, 16'h0800, 3, 1'b0});
        vecs.push_back('{"wr_nb12_sel12", 2'b10, 12, 8'h81, 0, 1'b1, 16'h0000, 1, 1'b1});
        vecs.push_back('{"mac_b12", 2'b00, 12, 8'h00, 0, 1'b0, 16'h1000, 6, 1'b0});

        #1;
        check_reset_outs("reset_hold");
        repeat (3) @(negedge clk);
        check_reset_outs("reset_hold2");
        rst_n = 1'b1;
        #1;
        check("reset_release", outs_t'({1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        @(negedge clk);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].name, vecs[i].op, vecs[i].sel, vecs[i].w, vecs[i].ab,
                    vecs[i].b12, 1'b0, 1'b1, vecs[i].exp_ben, vecs[i].exp_dc,
                    vecs[i].exp_err);
        end

        // Read with the next command already pending: no accept before an IDLE cycle
        run_cmd("rd_hold", 2'b01, 15, 8'h11, 0, 1'b0, 1'b1, 1'b0, 16'h0, 0, 1'b0);
        check_bit("idle_gap_ready", act.rdy, 1'b1);
        run_cmd("wr_after_hold", 2'b10, 0, 8'h3C, 0, 1'b0, 1'b0, 1'b1, 16'h0001, 4, 1'b0);

        // Reset asserted during ACTIVE
        use12 = 1'b0;
        cmd_valid = 1'b1; op_code = 2'b00; bank_sel = 4'd7; word = 8'h5A;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_active", model(2'b00, 7, 8'h5A, 0, 16, 2));
        rst_n = 1'b0;
        #1;
        check_reset_outs("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outs("reset_no_done");
        end
        rst_n = 1'b1;
        #1;
        check("post_reset_idle", outs_t'({1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        @(negedge clk);
        check("post_reset_idle2", outs_t'({1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            int sel, nb, ab;
            bit b12;
            b12 = 1'($urandom);
            nb  = b12 ? 12 : 16;
            op  = 2'($urandom);
            sel = int'($urandom_range(0, 15));
            ab  = 0;
            if (!is_skip(op, sel, nb) && ($urandom % 3 == 0))
                ab = int'($urandom_range(1, act_len(op) + 1));
            run_cmd("rand", op, sel, 8'($urandom), ab, b12, 1'b0, 1'b0, 16'h0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
